// File: rtl/exp_pkg.sv
// Shared definitions for the exponential-engine batch sequencer:
// operand/result widths, the sequencer state encoding and a small helper.
package exp_pkg;

  localparam int OPERAND_W = 16;
  localparam int UI_W      = 2;
  localparam int RESULT_W  = 21;
  localparam int SRC_W     = UI_W + OPERAND_W;
  localparam int TIMER_W   = 16;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LATCH,
    KICK,
    WAIT_RD,
    WAIT_WR,
    WAIT_DONE,
    NEXT,
    FINISH
  } seq_state_t;

  // True in the states where the sequencer is waiting on the engine and the
  // per-item watchdog is running.
  function automatic logic is_wait(input seq_state_t s);
    return (s == WAIT_RD) || (s == WAIT_WR) || (s == WAIT_DONE);
  endfunction

endpackage

// File: rtl/exp_seq_timeout.sv
// Per-item watchdog: a cycle counter that is cleared to zero, counts while
// enabled and flags expiry once it reaches LIMIT. It holds at LIMIT so the
// expired flag stays up until the next clear.
module exp_seq_timeout
  import exp_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TIMER_W-1:0] r_count;

  assign o_expired = (r_count == TIMER_W'(LIMIT));

  // Count engine-wait cycles; clear has priority so a new item starts at zero.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/exp_batch_sequencer.sv
// Batch controller for the exponential engine. Walks COUNT operand words
// from a source RAM, starts the engine for each one, writes each result to
// a destination RAM and reports completion or a per-item timeout abort.
// Engine pulses that arrive before the state that expects them are kept in
// seen_* flags, so rd/wr/done may all land in the same cycle.
// TIMEOUT must stay below 2^16 to fit the watchdog counter.
module exp_batch_sequencer
  import exp_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [ADDR_W-1:0]    i_count,
  input  logic [ADDR_W-1:0]    i_src_base,
  input  logic [ADDR_W-1:0]    i_dst_base,
  output logic [ADDR_W-1:0]    o_src_addr,
  input  logic [SRC_W-1:0]     i_src_data,
  output logic                 o_eng_start,
  output logic [OPERAND_W-1:0] o_eng_vi,
  output logic [UI_W-1:0]      o_eng_ui,
  input  logic                 i_eng_rd_req,
  input  logic                 i_eng_wr_req,
  input  logic [RESULT_W-1:0]  i_eng_wr_data,
  input  logic                 i_eng_done,
  output logic                 o_dst_we,
  output logic [ADDR_W-1:0]    o_dst_addr,
  output logic [RESULT_W-1:0]  o_dst_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout_err,
  output logic [ADDR_W-1:0]    o_items_done
);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [ADDR_W-1:0]    r_src_ptr;
  logic [ADDR_W-1:0]    r_dst_ptr;
  logic [ADDR_W-1:0]    r_remaining;
  logic [ADDR_W-1:0]    r_items_done;
  logic [OPERAND_W-1:0] r_eng_vi;
  logic [UI_W-1:0]      r_eng_ui;
  logic [RESULT_W-1:0]  r_wr_data;
  logic                 r_dst_we;
  logic                 r_timeout_err;
  logic                 r_seen_rd;
  logic                 r_seen_wr;
  logic                 r_seen_done;

  logic w_rd;
  logic w_wr;
  logic w_dn;
  logic w_waiting;
  logic w_expired;
  logic w_accept;
  logic w_write;
  logic w_abort;

  // A pulse counts if it is arriving now or was seen earlier in this item.
  assign w_rd      = i_eng_rd_req | r_seen_rd;
  assign w_wr      = i_eng_wr_req | r_seen_wr;
  assign w_dn      = i_eng_done   | r_seen_done;
  assign w_waiting = is_wait(r_state);

  exp_seq_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (r_state == KICK),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; also flags batch accept, result write and timeout abort.
  // Engine progress wins over an expiry seen in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_write      = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_next_state = (i_count == '0) ? FINISH : FETCH;
        end
      end
      FETCH: w_next_state = LATCH;
      LATCH: w_next_state = KICK;
      KICK:  w_next_state = WAIT_RD;
      WAIT_RD: begin
        if (w_rd && w_wr) begin
          w_write      = 1'b1;
          w_next_state = w_dn ? NEXT : WAIT_DONE;
        end else if (w_rd) begin
          w_next_state = WAIT_WR;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_next_state = FINISH;
        end
      end
      WAIT_WR: begin
        if (w_wr) begin
          w_write      = 1'b1;
          w_next_state = w_dn ? NEXT : WAIT_DONE;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_next_state = FINISH;
        end
      end
      WAIT_DONE: begin
        if (w_dn) begin
          w_next_state = NEXT;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_next_state = FINISH;
        end
      end
      NEXT:    w_next_state = (r_remaining == ADDR_W'(1)) ? FINISH : FETCH;
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Batch datapath: captured parameters, pointers, operand latch, write-back
  // strobe, completed-item count and the sticky abort flag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_src_ptr     <= '0;
      r_dst_ptr     <= '0;
      r_remaining   <= '0;
      r_items_done  <= '0;
      r_eng_vi      <= '0;
      r_eng_ui      <= '0;
      r_dst_we      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dst_we <= w_write;
      if (w_accept) begin
        r_src_ptr     <= i_src_base;
        r_dst_ptr     <= i_dst_base;
        r_remaining   <= i_count;
        r_items_done  <= '0;
        r_timeout_err <= 1'b0;
      end
      if (r_state == LATCH) begin
        {r_eng_ui, r_eng_vi} <= i_src_data;
      end
      if (r_state == NEXT) begin
        r_src_ptr   <= r_src_ptr + ADDR_W'(1);
        r_dst_ptr   <= r_dst_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - ADDR_W'(1);
      end
      if (w_write) begin
        r_items_done <= r_items_done + ADDR_W'(1);
      end
      if (w_abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Engine handshake memory: remember early pulses and capture the first
  // result of the item; everything is forgotten when the next item is kicked.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_seen_rd   <= 1'b0;
      r_seen_wr   <= 1'b0;
      r_seen_done <= 1'b0;
      r_wr_data   <= '0;
    end else if (r_state == KICK) begin
      r_seen_rd   <= 1'b0;
      r_seen_wr   <= 1'b0;
      r_seen_done <= 1'b0;
    end else if (w_waiting) begin
      r_seen_rd   <= r_seen_rd   | i_eng_rd_req;
      r_seen_wr   <= r_seen_wr   | i_eng_wr_req;
      r_seen_done <= r_seen_done | i_eng_done;
      if (i_eng_wr_req && !r_seen_wr) begin
        r_wr_data <= i_eng_wr_data;
      end
    end
  end

  assign o_src_addr    = r_src_ptr;
  assign o_eng_start   = (r_state == KICK);
  assign o_eng_vi      = r_eng_vi;
  assign o_eng_ui      = r_eng_ui;
  assign o_dst_we      = r_dst_we;
  assign o_dst_addr    = r_dst_ptr;
  assign o_dst_wdata   = r_wr_data;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = (r_state == FINISH);
  assign o_timeout_err = r_timeout_err;
  assign o_items_done  = r_items_done;

endmodule

// File: tb/tb_exp_batch_sequencer.sv
// Self-checking bench for exp_batch_sequencer: source RAM model, a simple
// echo engine model with selectable pulse timing, and a scoreboard of
// expected destination writes.
module tb_exp_batch_sequencer;
  import exp_pkg::*;

  localparam int MODE_NORMAL = 0;
  localparam int MODE_SAME   = 1;
  localparam int MODE_NOWR   = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  count;
  logic [7:0]  srcBase;
  logic [7:0]  dstBase;
  logic [7:0]  srcAddr;
  logic [17:0] srcData;
  logic        engStart;
  logic [15:0] engVi;
  logic [1:0]  engUi;
  logic        engRdReq;
  logic        engWrReq;
  logic [20:0] engWrData;
  logic        engDone;
  logic        dstWe;
  logic [7:0]  dstAddr;
  logic [20:0] dstWdata;
  logic        busy;
  logic        done;
  logic        timeoutErr;
  logic [7:0]  itemsDone;

  logic        modelRd;
  logic        modelWr;
  logic        modelDone;
  logic        injectWr;
  logic [20:0] engResult;
  logic [17:0] srcMem [256];
  logic [28:0] expQ [$];

  int checkCount    = 0;
  int failCount     = 0;
  int doneCount     = 0;
  int engStartCount = 0;
  int engMode       = MODE_NORMAL;
  int engPhase      = -1;

  assign engRdReq = modelRd;
  assign engWrReq = modelWr | injectWr;
  assign engDone  = modelDone;

  exp_batch_sequencer #(
    .ADDR_W  (8),
    .TIMEOUT (20)
  ) dut (
    .i_clock       (clock),
    .i_reset       (reset),
    .i_start       (start),
    .i_count       (count),
    .i_src_base    (srcBase),
    .i_dst_base    (dstBase),
    .o_src_addr    (srcAddr),
    .i_src_data    (srcData),
    .o_eng_start   (engStart),
    .o_eng_vi      (engVi),
    .o_eng_ui      (engUi),
    .i_eng_rd_req  (engRdReq),
    .i_eng_wr_req  (engWrReq),
    .i_eng_wr_data (engWrData),
    .i_eng_done    (engDone),
    .o_dst_we      (dstWe),
    .o_dst_addr    (dstAddr),
    .o_dst_wdata   (dstWdata),
    .o_busy        (busy),
    .o_done        (done),
    .o_timeout_err (timeoutErr),
    .o_items_done  (itemsDone)
  );

  always #5 clock = ~clock;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=hang expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Source RAM: data follows the address one cycle later.
  initial begin
    srcData = '0;
    forever begin
      @(negedge clock);
      srcData = srcMem[srcAddr];
    end
  end

  // Engine model: echoes {3'b0, ui, vi}; pulse timing set by engMode.
  initial begin
    modelRd   = 1'b0;
    modelWr   = 1'b0;
    modelDone = 1'b0;
    engWrData = 21'h1ABCDE;
    engResult = '0;
    forever begin
      @(negedge clock);
      modelRd   = 1'b0;
      modelWr   = 1'b0;
      modelDone = 1'b0;
      engWrData = 21'h1ABCDE;
      if (reset) begin
        engPhase = -1;
      end else if (engStart) begin
        engPhase  = 0;
        engResult = {3'b000, engUi, engVi};
      end else if (engPhase >= 0) begin
        engPhase++;
        case (engMode)
          MODE_SAME: begin
            if (engPhase == 1) begin
              modelRd   = 1'b1;
              modelWr   = 1'b1;
              modelDone = 1'b1;
              engWrData = engResult;
              engPhase  = -1;
            end
          end
          MODE_NOWR: begin
            if (engPhase == 1) begin
              modelRd  = 1'b1;
              engPhase = -1;
            end
          end
          default: begin
            if (engPhase == 1) modelRd = 1'b1;
            if (engPhase == 3) begin
              modelWr   = 1'b1;
              engWrData = engResult;
            end
            if (engPhase == 6) begin
              modelDone = 1'b1;
              engPhase  = -1;
            end
          end
        endcase
      end
    end
  end

  // Scoreboard side: every destination write must match the oldest expectation.
  initial begin
    logic [28:0] expWrite;
    forever begin
      @(negedge clock);
      if (done) doneCount++;
      if (engStart) engStartCount++;
      if (dstWe) begin
        if (expQ.size() == 0) begin
          checkOutput("dst_we_unexpected", 32'(dstWe), 32'd0);
        end else begin
          expWrite = expQ.pop_front();
          checkOutput("dst_addr", 32'(dstAddr), 32'(expWrite[28:21]));
          checkOutput("dst_wdata", 32'(dstWdata), 32'(expWrite[20:0]));
        end
      end
    end
  end

  task automatic startBatch(input logic [7:0] cnt, input logic [7:0] src, input logic [7:0] dst,
                            input int expWrites);
    for (int i = 0; i < expWrites; i++) begin
      logic [7:0] s;
      logic [7:0] d;
      s = src + 8'(i);
      d = dst + 8'(i);
      expQ.push_back({d, 3'b000, srcMem[s]});
    end
    @(negedge clock);
    count   = cnt;
    srcBase = src;
    dstBase = dst;
    start   = 1'b1;
    @(negedge clock);
    start   = 1'b0;
    count   = 8'($urandom);
    srcBase = 8'($urandom);
    dstBase = 8'($urandom);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("timeout_err_cleared", 32'(timeoutErr), 32'd0);
  endtask

  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!done && cycles < 400) begin
      @(negedge clock);
      cycles++;
    end
    if (!done) checkOutput("done_wait_expired", 32'(done), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] cnt, input logic [7:0] src, input logic [7:0] dst,
                               input int mode, input int expCycles);
    int doneBefore;
    int startsBefore;
    int cycles;
    int expItems;
    int expStarts;
    engMode      = mode;
    expItems     = (mode == MODE_NOWR) ? 0 : int'(cnt);
    expStarts    = (cnt == 0) ? 0 : ((mode == MODE_NOWR) ? 1 : int'(cnt));
    doneBefore   = doneCount;
    startsBefore = engStartCount;
    startBatch(cnt, src, dst, expItems);
    waitDone(cycles);
    checkOutput("done_latency", 32'(cycles), 32'(expCycles));
    checkOutput("items_done", 32'(itemsDone), 32'(expItems));
    checkOutput("timeout_err", 32'(timeoutErr), 32'(mode == MODE_NOWR));
    @(negedge clock);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("timeout_err_held", 32'(timeoutErr), 32'(mode == MODE_NOWR));
    checkOutput("done_pulses", 32'(doneCount - doneBefore), 32'd1);
    checkOutput("eng_starts", 32'(engStartCount - startsBefore), 32'(expStarts));
    checkOutput("writes_outstanding", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int seen;
    int guard;
    int doneBefore;
    logic [7:0] itemsBefore;

    reset    = 1'b1;
    start    = 1'b0;
    count    = '0;
    srcBase  = '0;
    dstBase  = '0;
    injectWr = 1'b0;
    for (int i = 0; i < 256; i++) srcMem[i] = 18'($urandom);
    srcMem[8'h10] = {2'd1, 16'h0001};
    srcMem[8'h11] = {2'd2, 16'h0100};
    srcMem[8'h12] = {2'd3, 16'hFFFF};

    repeat (3) @(negedge clock);
    checkOutput("reset_ctrl", 32'({busy, done, dstWe, engStart, timeoutErr, srcAddr, dstAddr, itemsDone}), 32'd0);
    checkOutput("reset_operand", 32'({engUi, engVi}), 32'd0);
    checkOutput("reset_wdata", 32'(dstWdata), 32'd0);
    reset = 1'b0;
    $display("[TB] reset released");

    // Three items through the full WAIT_RD/WAIT_WR/WAIT_DONE path.
    applyStimulus(8'd3, 8'h10, 8'h40, MODE_NORMAL, 31);

    // Stray write request while idle must not write or count.
    itemsBefore = itemsDone;
    @(negedge clock);
    injectWr = 1'b1;
    @(negedge clock);
    injectWr = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("idle_wr_items", 32'(itemsDone), 32'(itemsBefore));

    // Empty batch goes straight to FINISH.
    applyStimulus(8'd0, 8'h00, 8'h00, MODE_NORMAL, 1);

    // Pointer wrap-around on both memories.
    applyStimulus(8'd3, 8'hFE, 8'hFF, MODE_NORMAL, 31);

    // rd/wr/done in one cycle right after eng_start.
    applyStimulus(8'd4, 8'h80, 8'hC0, MODE_SAME, 21);

    // Engine never writes: abort after 21 wait cycles.
    applyStimulus(8'd2, 8'h50, 8'h90, MODE_NOWR, 25);

    // Next batch clears the sticky error and runs normally.
    applyStimulus(8'd2, 8'h60, 8'hA0, MODE_NORMAL, 21);

    // Reset during WAIT_DONE of the second item.
    engMode = MODE_NORMAL;
    startBatch(8'd3, 8'h20, 8'h60, 3);
    seen  = 0;
    guard = 0;
    while (seen < 2 && guard < 200) begin
      @(negedge clock);
      guard++;
      if (dstWe) seen++;
    end
    checkOutput("reset_test_item2_written", 32'(seen), 32'd2);
    doneBefore = doneCount;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_ctrl", 32'({busy, done, dstWe, engStart, timeoutErr, srcAddr, dstAddr, itemsDone}), 32'd0);
    checkOutput("midreset_operand", 32'({engUi, engVi}), 32'd0);
    checkOutput("midreset_wdata", 32'(dstWdata), 32'd0);
    reset = 1'b0;
    expQ.delete();
    repeat (10) @(negedge clock);
    checkOutput("midreset_no_done", 32'(doneCount - doneBefore), 32'd0);

    // Fresh batch after the abort-by-reset.
    applyStimulus(8'd4, 8'h30, 8'h70, MODE_NORMAL, 41);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
